// File: rtl/uart_frame_packer.sv
// Frames each kept filtered sample into a 6-byte packet and pushes it byte by byte
// into the UART TX FIFO, holding whenever the FIFO reports full.
module uart_frame_packer #(
  parameter logic [7:0] HDR0      = 8'hAA,
  parameter logic [7:0] HDR1      = 8'h55,
  parameter int         DECIM     = 1,
  parameter int         DECIM_BIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        fifo_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for a sample, sample_ready high
  // S_HDR0 | writing first sync byte
  // S_HDR1 | writing second sync byte
  // S_DH   | writing latched sample high byte
  // S_DL   | writing latched sample low byte
  // S_SEQ  | writing frame sequence number
  // S_CHK  | writing checksum, then seq advances
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DH   = 3'd3,
    S_DL   = 3'd4,
    S_SEQ  = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  localparam logic [DECIM_BIT-1:0] DCNT_LAST = DECIM_BIT'(DECIM - 1);

  state_t               state_q, state_d;
  logic [15:0]          sample_q, sample_d;
  logic [7:0]           seq_q, seq_d;
  logic [DECIM_BIT-1:0] dcnt_q, dcnt_d;
  logic [7:0]           chk;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    seq_d    = seq_q;
    dcnt_d   = dcnt_q;

    sample_ready = (state_q == IDLE);
    busy         = (state_q != IDLE);
    // Gated by reset so a frame aborted by reset emits nothing while reset is low.
    wr_uart      = (state_q != IDLE) && !fifo_full && reset;
    chk          = sample_q[15:8] + sample_q[7:0] + seq_q;

    case (state_q)
      S_HDR0:  w_data = HDR0;
      S_HDR1:  w_data = HDR1;
      S_DH:    w_data = sample_q[15:8];
      S_DL:    w_data = sample_q[7:0];
      S_SEQ:   w_data = seq_q;
      S_CHK:   w_data = chk;
      default: w_data = 8'h00;
    endcase

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          if (dcnt_q == DCNT_LAST) begin
            sample_d = sample_data;
            dcnt_d   = '0;
            state_d  = S_HDR0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      S_HDR0: if (wr_uart) state_d = S_HDR1;
      S_HDR1: if (wr_uart) state_d = S_DH;
      S_DH:   if (wr_uart) state_d = S_DL;
      S_DL:   if (wr_uart) state_d = S_SEQ;
      S_SEQ:  if (wr_uart) state_d = S_CHK;
      S_CHK: begin
        if (wr_uart) begin
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      seq_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      seq_q    <= seq_d;
      dcnt_q   <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: directed table, stall/reset corner sequences, random
// frames against a packet model, and a decimating instance checked via a byte queue.
module tb_uart_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] s_data, s_data4;
  logic        s_valid, s_valid4;
  logic        s_ready, s_ready4;
  logic        f_full, f_full4;
  logic [7:0]  w_data, w_data4;
  logic        wr, wr4;
  logic        busy, busy4;

  uart_frame_packer #(.DECIM(1)) u_dut (
    .clk(clk), .reset(rst_n), .sample_data(s_data), .sample_valid(s_valid),
    .sample_ready(s_ready), .fifo_full(f_full), .w_data(w_data),
    .wr_uart(wr), .busy(busy)
  );

  uart_frame_packer #(.DECIM(4)) u_dut4 (
    .clk(clk), .reset(rst_n), .sample_data(s_data4), .sample_valid(s_valid4),
    .sample_ready(s_ready4), .fifo_full(f_full4), .w_data(w_data4),
    .wr_uart(wr4), .busy(busy4)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] q4[$];
  logic [7:0] exp4[$];

  always @(negedge clk) if (wr4) q4.push_back(w_data4);

  typedef struct {
    logic [15:0] smp;
    int          stall_at;
    int          stall_len;
    logic [7:0]  seq;
    logic [7:0]  chk;
  } vec_t;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [15:0] s, input logic [7:0] q);
    int sum;
    sum = int'(s[15:8]) + int'(s[7:0]) + int'(q);
    return 8'(sum % 256);
  endfunction

  task automatic junk();
    s_valid = 1'($urandom_range(0, 1));
    s_data  = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; f_full = 1'b0; s_valid4 = 1'b0; f_full4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wdata", w_data, 0);
    check("rst_wr", wr, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", s_ready, 1);
  endtask

  // Offers one sample and checks the whole frame cycle by cycle, with an optional
  // fifo_full stall of stall_len cycles placed in front of byte stall_at.
  task automatic run_frame(input logic [15:0] s, input logic [7:0] eseq,
                           input logic [7:0] echk, input int stall_at, input int stall_len);
    logic [7:0] exp [6];
    exp = '{8'hAA, 8'h55, s[15:8], s[7:0], eseq, echk};
    wait_ready();
    s_data = s; s_valid = 1'b1;
    if (stall_at == 0) f_full = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 6; b++) begin
      if (b == stall_at) begin
        f_full = 1'b1;
        for (int c = 0; c < stall_len; c++) begin
          @(negedge clk);
          check("stall_wr", wr, 0);
          check("stall_data", w_data, exp[b]);
          check("stall_busy", busy, 1);
          @(posedge clk); #1;
          junk();
        end
        f_full = 1'b0;
      end
      @(negedge clk);
      check("byte_wr", wr, 1);
      check("byte_data", w_data, exp[b]);
      check("byte_ready", s_ready, 0);
      @(posedge clk); #1;
      if (b < 5) junk();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_ready", s_ready, 1);
    check("end_wdata", w_data, 0);
    check("end_wr", wr, 0);
  endtask

  int acc4 = 0;
  logic [7:0] seq4 = 8'd0;

  task automatic feed4(input logic [15:0] v);
    int n = 0;
    while (!s_ready4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready4_timeout", s_ready4, 1);
    s_data4 = v; s_valid4 = 1'b1;
    @(posedge clk); #1;
    s_valid4 = 1'b0;
    acc4++;
    if (acc4 % 4 == 0) begin
      exp4.push_back(8'hAA); exp4.push_back(8'h55);
      exp4.push_back(v[15:8]); exp4.push_back(v[7:0]);
      exp4.push_back(seq4); exp4.push_back(model_chk(v, seq4));
      seq4++;
    end
  endtask

  task automatic compare_q4(input string nm);
    check({nm, "_count"}, 16'(q4.size()), 16'(exp4.size()));
    for (int i = 0; i < exp4.size() && i < q4.size(); i++)
      check({nm, "_byte"}, q4[i], exp4[i]);
  endtask

  initial begin
    vec_t tbl[5];
    logic [7:0] const4 [12];
    logic [7:0] mseq;
    logic [15:0] smp;
    int sa;

    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; f_full = 1'b0;
    s_data4 = '0; s_valid4 = 1'b0; f_full4 = 1'b0;

    tbl[0] = '{16'h1234, -1, 0, 8'h00, 8'h46};
    tbl[1] = '{16'hFFFF, -1, 0, 8'h01, 8'hFF};
    tbl[2] = '{16'h0102,  3, 5, 8'h02, 8'h05};
    tbl[3] = '{16'h8080,  0, 2, 8'h03, 8'h03};
    tbl[4] = '{16'h00FF,  5, 1, 8'h04, 8'h03};

    // Decimate-by-4 instance: only every 4th accepted sample is framed.
    do_reset();
    q4.delete(); exp4.delete();
    for (int i = 1; i <= 8; i++) feed4(16'(i));
    repeat (20) @(posedge clk);
    #1;
    const4 = '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h00, 8'h04,
               8'hAA, 8'h55, 8'h00, 8'h08, 8'h01, 8'h09};
    check("decim_count", 16'(q4.size()), 16'd12);
    for (int i = 0; i < 12 && i < q4.size(); i++) check("decim_byte", q4[i], const4[i]);
    compare_q4("decim_model");
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      feed4(16'($urandom));
    end
    repeat (20) @(posedge clk);
    #1;
    compare_q4("decim_rand");

    // Directed table on the DECIM=1 instance.
    do_reset();
    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].smp, tbl[i].seq, tbl[i].chk, tbl[i].stall_at, tbl[i].stall_len);

    // Five-cycle stall in S_DL on a fresh seq.
    do_reset();
    run_frame(16'h1234, 8'h00, 8'h46, 3, 5);

    // Reset right after the HDR1 write aborts the frame.
    do_reset();
    wait_ready();
    s_data = 16'h5555; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk); check("abort_hdr0", w_data, 8'hAA);
    @(posedge clk); #1;
    @(negedge clk); check("abort_hdr1", w_data, 8'h55);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); check("abort_wr_in_rst", wr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_wr_after", wr, 0);
    check("abort_busy_after", busy, 0);
    run_frame(16'hABCD, 8'h00, 8'h78, -1, 0);

    // Sequence number wrap across 257 zero frames.
    do_reset();
    for (int k = 0; k < 257; k++)
      run_frame(16'h0000, 8'(k % 256), 8'(k % 256), -1, 0);

    // Random samples, gaps and stalls against the packet model.
    do_reset();
    mseq = 8'h00;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      smp = 16'($urandom);
      sa  = $urandom_range(0, 9);
      run_frame(smp, mseq, model_chk(smp, mseq), sa, $urandom_range(1, 4));
      mseq++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
